glitc_align_ctrl: RTL and testbench

Training controller for one GLITC input channel's data path. On `start_i` it resets the ISERDES and sweeps the 32 IDELAY taps. At each tap it tries all four bitslip alignments against a fixed training word and records the eye edges, then loads the final tap and re-aligns. It runs in the `clk_i` control domain and drives the data-path wrapper's `delay_clk_i`/`load_clk_i`/`bitslip_clk_i`/`serdes_rst_clk_i` inputs, which cross to the fast domains through flag synchronizers.

---
 rtl/glitc_align_ctrl.sv | 179 +++++++++++++++++
 tb/tb_glitc_align_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/glitc_align_ctrl.sv
// rtl/glitc_align_ctrl.sv - IDELAY tap sweep and bitslip training controller for one GLITC channel
//
// Purpose: resets the ISERDES, sweeps the 32 IDELAY taps and, at each tap,
// tries the four bitslip alignments against PATTERN while recording the eye.
// Optional feature macro: GLITC_ALIGN_CENTER_EN
//   defined     - full sweep, then load the eye centre and re-align
//   not defined - the first passing alignment ends training
//
// Ports:
//   clk_i            control clock (only clock)
//   rst_i            synchronous active-high reset
//   start_i          begin training; honoured only in IDLE/DONE/FAIL
//   sample_i[3:0]    deserialized word, already in clk_i domain
//   sample_valid_i   sample_i valid this cycle
//   delay_o[4:0]     IDELAY tap value
//   load_o           one-cycle IDELAY load pulse
//   bitslip_o        one-cycle bitslip pulse
//   serdes_rst_o     one-cycle ISERDES reset pulse
//   busy_o           training in progress
//   done_o           training succeeded, held until next start
//   fail_o           no usable tap, held until next start
//   eye_start_o[4:0] first passing tap
//   eye_stop_o[4:0]  last passing tap of the first contiguous run
module glitc_align_ctrl #(
   parameter logic [3:0] PATTERN       = 4'b1100,
   parameter int         SETTLE_CYCLES = 16,
   parameter int         MATCH_COUNT   = 64
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [3:0] sample_i,
   input  logic       sample_valid_i,
   output logic [4:0] delay_o,
   output logic       load_o,
   output logic       bitslip_o,
   output logic       serdes_rst_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       fail_o,
   output logic [4:0] eye_start_o,
   output logic [4:0] eye_stop_o
);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_SRST, S_LOAD, S_SETTLE, S_CHECK, S_SLIP, S_NEXT,
      S_FLOAD, S_FSETTLE, S_FCHECK, S_FSLIP, S_DONE, S_FAIL
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt;
   logic [7:0]    match_cnt;
   logic [1:0]    slip_cnt;
   logic          start_ok, in_check, hit, miss, pass;
`ifdef GLITC_ALIGN_CENTER_EN
   logic          found, closed;
   logic [5:0]    eye_sum;

   assign eye_sum = {1'b0, eye_start_o} + {1'b0, eye_stop_o};
`endif

   assign start_ok = start_i && (state == S_IDLE || state == S_DONE || state == S_FAIL);
   assign in_check = (state == S_CHECK) || (state == S_FCHECK);
   assign hit      = in_check && sample_valid_i && (sample_i == PATTERN);
   assign miss     = in_check && sample_valid_i && (sample_i != PATTERN);
   assign pass     = hit && (match_cnt == 8'(MATCH_COUNT - 1));

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE, S_DONE, S_FAIL: if (start_i) state_n = S_SRST;
         // SRST also holds off the first load so the reset pulse settles
         S_SRST:   if (cnt == CW'(SETTLE_CYCLES)) state_n = S_LOAD;
         S_LOAD:   state_n = S_SETTLE;
         S_SETTLE: if (cnt == CW'(SETTLE_CYCLES - 1)) state_n = S_CHECK;
         S_CHECK: begin
`ifdef GLITC_ALIGN_CENTER_EN
            if (pass) state_n = S_NEXT;
`else
            if (pass) state_n = S_DONE;
`endif
            else if (miss) state_n = (slip_cnt != 2'd3) ? S_SLIP : S_NEXT;
         end
         S_SLIP: state_n = S_SETTLE;
         S_NEXT: begin
`ifdef GLITC_ALIGN_CENTER_EN
            if (delay_o == 5'd31 || closed) state_n = found ? S_FLOAD : S_FAIL;
`else
            if (delay_o == 5'd31) state_n = S_FAIL;
`endif
            else state_n = S_LOAD;
         end
`ifdef GLITC_ALIGN_CENTER_EN
         S_FLOAD:   state_n = S_FSETTLE;
         S_FSETTLE: if (cnt == CW'(SETTLE_CYCLES - 1)) state_n = S_FCHECK;
         S_FCHECK: begin
            if (pass) state_n = S_DONE;
            else if (miss) state_n = (slip_cnt != 2'd3) ? S_FSLIP : S_FAIL;
         end
         S_FSLIP: state_n = S_FSETTLE;
`endif
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         cnt          <= '0;
         match_cnt    <= '0;
         slip_cnt     <= '0;
         delay_o      <= '0;
         load_o       <= 1'b0;
         bitslip_o    <= 1'b0;
         serdes_rst_o <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         fail_o       <= 1'b0;
         eye_start_o  <= '0;
         eye_stop_o   <= '0;
`ifdef GLITC_ALIGN_CENTER_EN
         found        <= 1'b0;
         closed       <= 1'b0;
`endif
      end else begin
         state        <= state_n;
         cnt          <= (state_n != state) ? '0 : cnt + CW'(1);
         // a new state always starts a fresh match run; invalid cycles keep the count
         match_cnt    <= (state_n != state) ? '0 : (hit ? match_cnt + 8'd1 : match_cnt);
         // pulses are registered so they line up with the delay_o update
         serdes_rst_o <= (state == S_SRST) && (cnt == '0);
         load_o       <= (state_n == S_LOAD) || (state_n == S_FLOAD);
         bitslip_o    <= (state_n == S_SLIP) || (state_n == S_FSLIP);
         busy_o       <= !(state_n == S_IDLE || state_n == S_DONE || state_n == S_FAIL);
         done_o       <= (state_n == S_DONE);
         fail_o       <= (state_n == S_FAIL);

         if (start_ok || state == S_NEXT || state == S_FLOAD)
            slip_cnt <= '0;
         else if (state == S_SLIP || state == S_FSLIP)
            slip_cnt <= slip_cnt + 2'd1;

         if (start_ok) begin
            delay_o     <= '0;
            eye_start_o <= '0;
            eye_stop_o  <= '0;
`ifdef GLITC_ALIGN_CENTER_EN
            found       <= 1'b0;
            closed      <= 1'b0;
`endif
         end else begin
            if (state == S_NEXT && state_n == S_LOAD)
               delay_o <= delay_o + 5'd1;
`ifdef GLITC_ALIGN_CENTER_EN
            if (state_n == S_FLOAD)
               delay_o <= eye_sum[5:1];
            if (state == S_CHECK && pass) begin
               if (!found) begin
                  found       <= 1'b1;
                  eye_start_o <= delay_o;
                  eye_stop_o  <= delay_o;
               end else if (!closed) begin
                  eye_stop_o  <= delay_o;
               end
            end
            // four failed alignments after a pass mark the end of the first eye
            if (state == S_CHECK && miss && slip_cnt == 2'd3 && found)
               closed <= 1'b1;
`else
            if (state == S_CHECK && pass) begin
               eye_start_o <= delay_o;
               eye_stop_o  <= delay_o;
            end
`endif
         end
      end
   end
endmodule

// File: tb/tb_glitc_align_ctrl.sv
// tb/tb_glitc_align_ctrl.sv - self-checking bench for glitc_align_ctrl
module tb_glitc_align_ctrl;
   localparam logic [3:0] PAT    = 4'b1100;
   localparam int         SETTLE = 4;
   localparam int         MATCH  = 5;
`ifdef GLITC_ALIGN_CENTER_EN
   localparam bit CENTER = 1'b1;
`else
   localparam bit CENTER = 1'b0;
`endif

   logic       clk, rst_i, start_i, sample_valid_i;
   logic [3:0] sample_i;
   logic [4:0] delay_o, eye_start_o, eye_stop_o;
   logic       load_o, bitslip_o, serdes_rst_o, busy_o, done_o, fail_o;

   glitc_align_ctrl #(.PATTERN(PAT), .SETTLE_CYCLES(SETTLE), .MATCH_COUNT(MATCH)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .sample_i(sample_i),
      .sample_valid_i(sample_valid_i), .delay_o(delay_o), .load_o(load_o),
      .bitslip_o(bitslip_o), .serdes_rst_o(serdes_rst_o), .busy_o(busy_o),
      .done_o(done_o), .fail_o(fail_o), .eye_start_o(eye_start_o), .eye_stop_o(eye_stop_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // data-path emulation: a tap passes when it is inside the eye mask and the
   // number of bitslips since the last ISERDES reset hits the wanted phase
   logic [31:0] eye_mask = '0;
   int need_ph = 0, valid_pct = 100;
   int tap_cur = 0, ph_cur = 0;
   int n_load = 0, n_slip = 0, n_srst = 0;
   int cyc = 0, last_pulse = -1000;

   typedef struct {
      int done, fail, start, stop, dly, loads, slips;
   } res_t;

   typedef struct {
      logic [31:0] mask;
      int ph, fail, start, stop, dly, loads, slips;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (serdes_rst_o) ph_cur = 0;
      if (load_o) tap_cur = int'(delay_o);
      if (bitslip_o) ph_cur = (ph_cur + 1) % 4;
   end

   always @(negedge clk) begin
      sample_valid_i = ($urandom_range(99) < valid_pct);
      if (eye_mask[tap_cur] && ph_cur == need_ph) sample_i = PAT;
      else sample_i = PAT ^ 4'($urandom_range(15, 1));
   end

   always @(negedge clk) begin
      cyc++;
      if (load_o) n_load++;
      if (bitslip_o) n_slip++;
      if (serdes_rst_o) n_srst++;
      if (int'(load_o) + int'(bitslip_o) + int'(serdes_rst_o) > 1)
         chk("pulse_overlap", int'(load_o) + int'(bitslip_o) + int'(serdes_rst_o), 1);
      if (load_o || bitslip_o || serdes_rst_o) begin
         chk("pulse_gap_ok", int'(cyc - last_pulse >= SETTLE), 1);
         last_pulse = cyc;
      end
   end

   function automatic logic [31:0] span(input int lo, input int hi);
      logic [31:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   // reference: walk the taps, trying up to four word phases per tap
   function automatic res_t model(input logic [31:0] mask, input int ph);
      res_t r = '{0, 0, 0, 0, 0, 0, 0};
      int p = 0;
      bit found = 0, closed = 0, ok;
      for (int t = 0; t < 32; t++) begin
         r.loads++;
         r.dly = t;
         ok = 0;
         for (int k = 0; k < 4; k++) begin
            if (mask[t] && p == ph) begin ok = 1; break; end
            if (k < 3) begin p = (p + 1) % 4; r.slips++; end
         end
         if (ok) begin
            if (!CENTER) begin
               r.done = 1; r.start = t; r.stop = t;
               return r;
            end
            if (!found) begin found = 1; r.start = t; r.stop = t; end
            else if (!closed) r.stop = t;
         end else if (found) closed = 1;
         if (closed) break;
      end
      if (!CENTER || !found) begin
         r.fail = 1;
         return r;
      end
      r.dly = (r.start + r.stop) / 2;
      r.loads++;
      for (int k = 0; k < 4; k++) begin
         if (mask[r.dly] && p == ph) begin r.done = 1; return r; end
         if (k < 3) begin p = (p + 1) % 4; r.slips++; end
      end
      r.fail = 1;
      return r;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_i = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      rst_i = 1'b0;
      last_pulse = -1000;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".delay"}, int'(delay_o), 0);
      chk({tag, ".load"}, int'(load_o), 0);
      chk({tag, ".bitslip"}, int'(bitslip_o), 0);
      chk({tag, ".serdes_rst"}, int'(serdes_rst_o), 0);
      chk({tag, ".busy"}, int'(busy_o), 0);
      chk({tag, ".done"}, int'(done_o), 0);
      chk({tag, ".fail"}, int'(fail_o), 0);
      chk({tag, ".eye_start"}, int'(eye_start_o), 0);
      chk({tag, ".eye_stop"}, int'(eye_stop_o), 0);
   endtask

   task automatic run_case(input string tag, input logic [31:0] mask, input int ph,
                           input int vp, input bit noisy, input res_t exp);
      bit finished = 0;
      eye_mask = mask;
      need_ph = ph;
      valid_pct = vp;
      @(negedge clk);
      n_load = 0; n_slip = 0; n_srst = 0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk);
         if (done_o || fail_o) begin finished = 1; break; end
         start_i = noisy && ($urandom_range(49) == 0);
      end
      start_i = 1'b0;
      chk({tag, ".finished"}, int'(finished), 1);
      if (!finished) begin
         do_reset();
      end else begin
         repeat (3) @(negedge clk);
         chk({tag, ".done"}, int'(done_o), exp.done);
         chk({tag, ".fail"}, int'(fail_o), exp.fail);
         chk({tag, ".busy"}, int'(busy_o), 0);
         chk({tag, ".eye_start"}, int'(eye_start_o), exp.start);
         chk({tag, ".eye_stop"}, int'(eye_stop_o), exp.stop);
         chk({tag, ".delay"}, int'(delay_o), exp.dly);
         chk({tag, ".loads"}, n_load, exp.loads);
         chk({tag, ".slips"}, n_slip, exp.slips);
         chk({tag, ".srsts"}, n_srst, 1);
      end
   endtask

   vec_t tv[5];

   initial begin
      bit   hit;
      res_t e;
      logic [31:0] m;
      int lo, hi, lo2;

      tv[0] = '{span(10, 20), 0, 0, 10, CENTER ? 20 : 10, CENTER ? 15 : 10, CENTER ? 23 : 11, CENTER ? 36 : 32};
      tv[1] = '{span(4, 8), 2, 0, 4, CENTER ? 8 : 4, CENTER ? 6 : 4, CENTER ? 11 : 5, CENTER ? 18 : 14};
      tv[2] = '{32'h0, 1, 1, 0, 0, 31, 32, 96};
      tv[3] = '{span(3, 5) | span(20, 25), 1, 0, 3, CENTER ? 5 : 3, CENTER ? 4 : 3, CENTER ? 8 : 4, CENTER ? 13 : 9};
      tv[4] = '{span(9, 31), 3, 0, 9, CENTER ? 31 : 9, CENTER ? 20 : 9, CENTER ? 33 : 10, 27};

      rst_i = 1'b1;
      start_i = 1'b0;
      sample_i = '0;
      sample_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_i = 1'b0;

      // start latency: SRST on first edge, serdes_rst_o on the second
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("start.edge1_srst", int'(serdes_rst_o), 0);
      chk("start.edge1_busy", int'(busy_o), 1);
      @(negedge clk);
      chk("start.edge2_srst", int'(serdes_rst_o), 1);

      // reset during SLIP at tap 7
      eye_mask = '0;
      hit = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (bitslip_o && delay_o == 5'd7) begin hit = 1; break; end
      end
      chk("midrst.reached_slip7", int'(hit), 1);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      last_pulse = -1000;
      check_reset_vals("midrst");
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("restart.busy", int'(busy_o), 1);
      chk("restart.delay", int'(delay_o), 0);
      do_reset();

      for (int i = 0; i < 5; i++) begin
         e = '{tv[i].fail ? 0 : 1, tv[i].fail, tv[i].start, tv[i].stop, tv[i].dly, tv[i].loads, tv[i].slips};
         run_case($sformatf("vec%0d", i), tv[i].mask, tv[i].ph, 60, 1'b0, e);
      end

      for (int i = 0; i < 16; i++) begin
         case ($urandom_range(3))
            0: m = '0;
            1: begin
               lo = $urandom_range(31);
               hi = lo + $urandom_range(31 - lo);
               m = span(lo, hi);
            end
            2: begin
               lo = $urandom_range(20);
               hi = lo + $urandom_range(4);
               lo2 = hi + $urandom_range(5, 2);
               m = span(lo, hi) | span(lo2, (lo2 + $urandom_range(5) > 31) ? 31 : lo2 + $urandom_range(5));
            end
            default: m = span(0, 31) & (32'h1 << $urandom_range(31));
         endcase
         lo = $urandom_range(3);
         run_case($sformatf("rnd%0d", i), m, lo, $urandom_range(100, 50), 1'b1, model(m, lo));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
